game_flow_ctrl: RTL and testbench
=================================

Name: game_flow_ctrl

Overview:
Parametrised turn/game-flow controller for N-player grid games. It is the successor of the two-player tic-tac-toe flow FSM.
- Sequences player turns and rejects invalid moves with a timed indicator.
- Detects game end from an external win checker and its own move count.
- Keeps per-player saturating scores and rotates the starting player between games.
- Sits between the input/move-decode logic and the board/win-check and display blocks.

Parameters:
NUM_PLAYERS, 2, number of players (2..8); PW = max(1, $clog2(NUM_PLAYERS))
MAX_MOVES, 9, moves that fill the board; reaching it without a win is a draw; MCW = $clog2(MAX_MOVES+1)
INVALID_HOLD, 4, cycles LED_invalid stays high after a rejected move (>=1)
SCORE_W, 4, width of each per-player score counter

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
restart  in  1  active-high, sampled each cycle; starts a new game
score_clr  in  1  active-high, clears all scores (synchronous)
move_req  in  1  one-cycle pulse: current player submits a move
move_invalid  in  1  qualifies move_req: submitted cell is illegal
win  in  1  win-checker result for cur_player, valid in the CHECK cycle
cur_player  out  PW  index of player to move
en_player  out  NUM_PLAYERS  one-hot move enable for cur_player; 0 outside TURN
LED_invalid  out  1  rejected-move indicator
move_cnt  out  MCW  accepted moves this game
game_over  out  1  high in OVER
draw_flag  out  1  high in OVER when the game ended without a winner
winner  out  NUM_PLAYERS  one-hot winner; 0 unless won
scores  out  NUM_PLAYERS*SCORE_W  player p score at [p*SCORE_W +: SCORE_W]

Behaviour:
- Reset (reset=0, async) values:
  - state=TURN; cur_player=0; start_player=0; move_cnt=0.
  - LED_invalid=0; game_over=0; draw_flag=0; winner=0; scores=0.
  - en_player=1 (player 0 enabled).
- Output timing: all outputs are registered or decoded from registered state. There is no combinational input-to-output path.
- TURN state:
  - en_player = 1<<cur_player.
  - move_req & move_invalid: go to INVALID; load hold counter with INVALID_HOLD.
  - move_req & !move_invalid: move_cnt+1; go to CHECK.
  - No move_req: stay in TURN.
- CHECK state (exactly 1 cycle, en_player=0):
  - win=1: go to OVER; winner=1<<cur_player; that player's score +1, saturating at 2^SCORE_W-1.
  - Else if move_cnt==MAX_MOVES: go to OVER; draw_flag=1.
  - Else: cur_player advances (NUM_PLAYERS-1 wraps to 0); go to TURN.
  - win takes priority over the draw condition on the final move.
- INVALID state:
  - LED_invalid=1 for exactly INVALID_HOLD cycles; en_player=0; move_req ignored.
  - Then return to TURN with the same cur_player. move_cnt is unchanged.
- OVER state:
  - game_over=1; winner and draw_flag are held; move_req ignored.
- restart=1, highest priority below reset, in any state. On the next edge:
  - From OVER: start_player advances (with wrap).
  - From any other state (abort): start_player is unchanged and no score changes.
  - Then in all cases: cur_player=new start_player; move_cnt=0; winner=0; draw_flag=0; LED_invalid=0; state=TURN.
  - restart held high keeps the FSM re-entering TURN. start_player advances only on the first cycle leaving OVER.
- score_clr=1: all scores go to 0 on the next edge, independent of state. If coincident with a CHECK win increment, the clear wins.
- move_req in the same cycle as restart is dropped.
- Unused state encodings return to TURN. They must not lock up.

Test Plan:
- NUM_PLAYERS=2: valid moves P0 then P1 alternate; on the 3rd move win=1 in CHECK -> game_over=1, winner=2'b01, scores[3:0]=1, move_cnt=3.
- move_req+move_invalid in TURN -> LED_invalid high exactly 4 cycles, en_player=0 meanwhile, then same player enabled, move_cnt unchanged.
- 9 valid moves with win=0 -> after 9th CHECK: draw_flag=1, winner=0, scores unchanged. Repeat with win=1 on the 9th -> win reported, draw_flag=0.
- NUM_PLAYERS=3: cur_player sequence 0,1,2,0. Restart from OVER -> next game starts with player 1. Restart mid-game -> start player unchanged, move_cnt=0.
- SCORE_W=2: player 0 wins 4 games -> score stays 3. score_clr -> all scores 0.
- Assert reset low mid-INVALID asynchronously -> all outputs at reset values before the next clock edge.

Source files
------------

// File: rtl/game_flow_ctrl.sv
// Turn and game-flow controller for N-player grid games. It sequences turns,
// flags rejected moves, detects a win or a draw, and keeps saturating scores.
module game_flow_ctrl #(
  parameter int  NUM_PLAYERS  = 2,
  parameter int  MAX_MOVES    = 9,
  parameter int  INVALID_HOLD = 4,
  parameter int  SCORE_W      = 4,
  localparam int PW  = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1,
  localparam int MCW = $clog2(MAX_MOVES + 1)
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           restart,
  input  logic                           score_clr,
  input  logic                           move_req,
  input  logic                           move_invalid,
  input  logic                           win,
  output logic [PW-1:0]                  cur_player,
  output logic [NUM_PLAYERS-1:0]         en_player,
  output logic                           LED_invalid,
  output logic [MCW-1:0]                 move_cnt,
  output logic                           game_over,
  output logic                           draw_flag,
  output logic [NUM_PLAYERS-1:0]         winner,
  output logic [NUM_PLAYERS*SCORE_W-1:0] scores
);

  localparam int HW = $clog2(INVALID_HOLD + 1);
  localparam logic [PW-1:0]          LAST_PLAYER = PW'(NUM_PLAYERS - 1);
  localparam logic [MCW-1:0]         FULL_BOARD  = MCW'(MAX_MOVES);
  localparam logic [HW-1:0]          HOLD_LOAD   = HW'(INVALID_HOLD);
  localparam logic [NUM_PLAYERS-1:0] ONE_HOT0    = NUM_PLAYERS'(1);
  localparam logic [SCORE_W-1:0]     SCORE_MAX   = '1;

  typedef enum logic [1:0] {
    ST_TURN    = 2'd0,
    ST_CHECK   = 2'd1,
    ST_INVALID = 2'd2,
    ST_OVER    = 2'd3
  } state_e;

  state_e                          state_q;
  logic [PW-1:0]                   cur_q;
  logic [PW-1:0]                   start_q;
  logic [MCW-1:0]                  cnt_q;
  logic [HW-1:0]                   hold_q;
  logic                            led_q;
  logic                            over_q;
  logic                            draw_q;
  logic [NUM_PLAYERS-1:0]          winner_q;
  logic [NUM_PLAYERS*SCORE_W-1:0]  scores_q;
  logic [NUM_PLAYERS*SCORE_W-1:0]  scores_d;
  logic [PW-1:0]                   curInc;
  logic [PW-1:0]                   startInc;
  logic                            scoreWin;

  assign curInc   = (cur_q == LAST_PLAYER) ? '0 : cur_q + 1'b1;
  assign startInc = (start_q == LAST_PLAYER) ? '0 : start_q + 1'b1;

  // restart outranks everything except reset; a move arriving with it is dropped
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_TURN;
      cur_q    <= '0;
      start_q  <= '0;
      cnt_q    <= '0;
      hold_q   <= '0;
      led_q    <= 1'b0;
      over_q   <= 1'b0;
      draw_q   <= 1'b0;
      winner_q <= '0;
    end else if (restart) begin
      if (state_q == ST_OVER) begin
        start_q <= startInc;
        cur_q   <= startInc;
      end else begin
        cur_q   <= start_q;
      end
      state_q  <= ST_TURN;
      cnt_q    <= '0;
      hold_q   <= '0;
      led_q    <= 1'b0;
      over_q   <= 1'b0;
      draw_q   <= 1'b0;
      winner_q <= '0;
    end else begin
      case (state_q)
        ST_TURN: begin
          if (move_req) begin
            if (move_invalid) begin
              state_q <= ST_INVALID;
              hold_q  <= HOLD_LOAD;
              led_q   <= 1'b1;
            end else begin
              state_q <= ST_CHECK;
              cnt_q   <= cnt_q + 1'b1;
            end
          end
        end
        ST_CHECK: begin
          if (win) begin
            state_q  <= ST_OVER;
            over_q   <= 1'b1;
            winner_q <= ONE_HOT0 << cur_q;
          end else if (cnt_q == FULL_BOARD) begin
            state_q <= ST_OVER;
            over_q  <= 1'b1;
            draw_q  <= 1'b1;
          end else begin
            state_q <= ST_TURN;
            cur_q   <= curInc;
          end
        end
        ST_INVALID: begin
          hold_q <= hold_q - 1'b1;
          if (hold_q <= HW'(1)) begin
            state_q <= ST_TURN;
            led_q   <= 1'b0;
          end
        end
        ST_OVER: begin
          state_q <= ST_OVER;
        end
        default: begin
          state_q <= ST_TURN;
          led_q   <= 1'b0;
          over_q  <= 1'b0;
        end
      endcase
    end
  end

  // A clear in the same cycle as a winning CHECK takes precedence over the increment
  assign scoreWin = (state_q == ST_CHECK) && win && !restart;

  always_comb begin
    scores_d = scores_q;
    if (score_clr) begin
      scores_d = '0;
    end else if (scoreWin) begin
      for (int p = 0; p < NUM_PLAYERS; p++) begin
        if ((cur_q == PW'(p)) && (scores_q[p*SCORE_W +: SCORE_W] != SCORE_MAX)) begin
          scores_d[p*SCORE_W +: SCORE_W] = scores_q[p*SCORE_W +: SCORE_W] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      scores_q <= '0;
    end else begin
      scores_q <= scores_d;
    end
  end

  assign cur_player  = cur_q;
  assign en_player   = (state_q == ST_TURN) ? (ONE_HOT0 << cur_q) : '0;
  assign LED_invalid = led_q;
  assign move_cnt    = cnt_q;
  assign game_over   = over_q;
  assign draw_flag   = draw_q;
  assign winner      = winner_q;
  assign scores      = scores_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Bench for game_flow_ctrl: a two-player and a three-player instance share one
// stimulus stream and are both checked every cycle against a turn-level model.
module tb_game_flow_ctrl;

  logic clock = 1'b0;
  logic reset;
  logic restart, scoreClr, moveReq, moveInvalid, winIn;

  logic [0:0] aCur;  logic [1:0] aEn;  logic aLed;  logic [3:0] aCnt;
  logic aOver, aDraw; logic [1:0] aWinner; logic [7:0] aScores;
  logic [1:0] bCur;  logic [2:0] bEn;  logic bLed;  logic [3:0] bCnt;
  logic bOver, bDraw; logic [2:0] bWinner; logic [5:0] bScores;

  int testsRun = 0;
  int testsFailed = 0;
  bit checkEn = 1'b0;

  always #5 clock = ~clock;

  game_flow_ctrl #(.NUM_PLAYERS(2), .MAX_MOVES(9), .INVALID_HOLD(4), .SCORE_W(4)) dutA (
    .clock(clock), .reset(reset), .restart(restart), .score_clr(scoreClr),
    .move_req(moveReq), .move_invalid(moveInvalid), .win(winIn),
    .cur_player(aCur), .en_player(aEn), .LED_invalid(aLed), .move_cnt(aCnt),
    .game_over(aOver), .draw_flag(aDraw), .winner(aWinner), .scores(aScores)
  );

  game_flow_ctrl #(.NUM_PLAYERS(3), .MAX_MOVES(9), .INVALID_HOLD(4), .SCORE_W(2)) dutB (
    .clock(clock), .reset(reset), .restart(restart), .score_clr(scoreClr),
    .move_req(moveReq), .move_invalid(moveInvalid), .win(winIn),
    .cur_player(bCur), .en_player(bEn), .LED_invalid(bLed), .move_cnt(bCnt),
    .game_over(bOver), .draw_flag(bDraw), .winner(bWinner), .scores(bScores)
  );

  // Model: phase of play per instance, turn owner, start player and score table
  localparam int PH_TURN = 0, PH_CHECK = 1, PH_INVALID = 2, PH_OVER = 3;
  int mPhase[2], mCur[2], mStart[2], mCnt[2], mHold[2], mDraw[2], mWinner[2];
  int mScore[2][8];

  task automatic checkOutput(input string name, input int act, input int exp);
    testsRun++;
    if (act != exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    for (int k = 0; k < 2; k++) begin
      mPhase[k] = PH_TURN; mCur[k] = 0; mStart[k] = 0; mCnt[k] = 0;
      mHold[k] = 0; mDraw[k] = 0; mWinner[k] = -1;
      for (int p = 0; p < 8; p++) mScore[k][p] = 0;
    end
  endtask

  task automatic stepModel(input int k);
    int np   = (k == 0) ? 2 : 3;
    int sMax = (k == 0) ? 15 : 3;
    if (restart) begin
      if (mPhase[k] == PH_OVER) mStart[k] = (mStart[k] + 1) % np;
      mCur[k] = mStart[k]; mCnt[k] = 0; mWinner[k] = -1; mDraw[k] = 0;
      mHold[k] = 0; mPhase[k] = PH_TURN;
    end else begin
      case (mPhase[k])
        PH_TURN: if (moveReq) begin
          if (moveInvalid) begin
            mPhase[k] = PH_INVALID; mHold[k] = 4;
          end else begin
            mCnt[k]++; mPhase[k] = PH_CHECK;
          end
        end
        PH_CHECK: begin
          if (winIn) begin
            mPhase[k] = PH_OVER; mWinner[k] = mCur[k];
            if (mScore[k][mCur[k]] < sMax) mScore[k][mCur[k]]++;
          end else if (mCnt[k] == 9) begin
            mPhase[k] = PH_OVER; mDraw[k] = 1;
          end else begin
            mCur[k] = (mCur[k] + 1) % np; mPhase[k] = PH_TURN;
          end
        end
        PH_INVALID: begin
          mHold[k]--;
          if (mHold[k] == 0) mPhase[k] = PH_TURN;
        end
        default: ;
      endcase
    end
    if (scoreClr) for (int p = 0; p < 8; p++) mScore[k][p] = 0;
  endtask

  always @(posedge clock or negedge reset) begin
    if (!reset) modelReset();
    else for (int k = 0; k < 2; k++) stepModel(k);
  end

  function automatic int expEn(input int k);
    return (mPhase[k] == PH_TURN) ? (1 << mCur[k]) : 0;
  endfunction

  function automatic int expScores(input int k);
    int sw = (k == 0) ? 4 : 2;
    int v = 0;
    for (int p = 0; p < 3; p++) v = v | (mScore[k][p] << (p * sw));
    return v;
  endfunction

  always @(negedge clock) begin
    if (checkEn) begin
      checkOutput("A.cur_player", int'(aCur), mCur[0]);
      checkOutput("A.en_player", int'(aEn), expEn(0));
      checkOutput("A.LED_invalid", int'(aLed), int'(mPhase[0] == PH_INVALID));
      checkOutput("A.move_cnt", int'(aCnt), mCnt[0]);
      checkOutput("A.game_over", int'(aOver), int'(mPhase[0] == PH_OVER));
      checkOutput("A.draw_flag", int'(aDraw), mDraw[0]);
      checkOutput("A.winner", int'(aWinner), (mWinner[0] >= 0) ? (1 << mWinner[0]) : 0);
      checkOutput("A.scores", int'(aScores), expScores(0));
      checkOutput("B.cur_player", int'(bCur), mCur[1]);
      checkOutput("B.en_player", int'(bEn), expEn(1));
      checkOutput("B.LED_invalid", int'(bLed), int'(mPhase[1] == PH_INVALID));
      checkOutput("B.move_cnt", int'(bCnt), mCnt[1]);
      checkOutput("B.game_over", int'(bOver), int'(mPhase[1] == PH_OVER));
      checkOutput("B.draw_flag", int'(bDraw), mDraw[1]);
      checkOutput("B.winner", int'(bWinner), (mWinner[1] >= 0) ? (1 << mWinner[1]) : 0);
      checkOutput("B.scores", int'(bScores), expScores(1));
    end
  end

  // Drives one cycle of inputs from a falling edge and returns at the next one
  task automatic applyStimulus(input bit req, input bit inv, input bit w,
                               input bit rst, input bit clr);
    moveReq = req; moveInvalid = inv; winIn = w; restart = rst; scoreClr = clr;
    @(negedge clock);
  endtask

  task automatic clearInputs();
    moveReq = 0; moveInvalid = 0; winIn = 0; restart = 0; scoreClr = 0;
  endtask

  task automatic playValid(input bit w, input bit clr);
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(0, 0, w, 0, clr);
    clearInputs();
  endtask

  task automatic pulseRestart(input int cycles);
    repeat (cycles) applyStimulus(0, 0, 0, 1, 0);
    clearInputs();
  endtask

  initial begin
    reset = 1'b0;
    clearInputs();
    modelReset();
    @(negedge clock);
    checkEn = 1'b1;
    checkOutput("reset A.en", int'(aEn), 1);
    checkOutput("reset B.en", int'(bEn), 1);
    checkOutput("reset A.scores", int'(aScores), 0);
    reset = 1'b1;
    @(negedge clock);

    // Game 1: three moves, the third one wins
    playValid(0, 0); playValid(0, 0); playValid(1, 0);
    checkOutput("g1 A.winner", int'(aWinner), 1);
    checkOutput("g1 A.scores", int'(aScores), 8'h01);
    checkOutput("g1 A.move_cnt", int'(aCnt), 3);
    checkOutput("g1 A.game_over", int'(aOver), 1);
    checkOutput("g1 B.winner", int'(bWinner), 3'b100);
    pulseRestart(1);
    checkOutput("g2 B.start", int'(bCur), 1);
    checkOutput("g2 A.start", int'(aCur), 1);

    // Game 2: a rejected move holds the indicator for four cycles
    applyStimulus(1, 1, 0, 0, 0);
    clearInputs();
    for (int i = 0; i < 4; i++) begin
      checkOutput("inv A.LED_invalid", int'(aLed), 1);
      checkOutput("inv A.en_player", int'(aEn), 0);
      applyStimulus(0, 0, 0, 0, 0);
    end
    checkOutput("inv end A.LED_invalid", int'(aLed), 0);
    checkOutput("inv end A.en_player", int'(aEn), 2'b10);
    checkOutput("inv end A.move_cnt", int'(aCnt), 0);
    playValid(0, 0); playValid(0, 0); playValid(1, 0);
    checkOutput("g2 B.winner", int'(bWinner), 3'b001);
    pulseRestart(1);

    // Game 3: board fills with no winner
    repeat (9) playValid(0, 0);
    checkOutput("draw A.draw_flag", int'(aDraw), 1);
    checkOutput("draw A.winner", int'(aWinner), 0);
    checkOutput("draw A.move_cnt", int'(aCnt), 9);
    checkOutput("draw A.scores", int'(aScores), 8'h11);
    pulseRestart(1);

    // Game 4: three-player rotation, then a win on the final move
    for (int i = 0; i < 9; i++) begin
      if (i < 4) checkOutput("rot B.cur_player", int'(bCur), (i == 3) ? 0 : i);
      playValid(i == 8, 0);
    end
    checkOutput("lastwin A.winner", int'(aWinner), 2'b10);
    checkOutput("lastwin A.draw_flag", int'(aDraw), 0);
    checkOutput("lastwin A.move_cnt", int'(aCnt), 9);
    pulseRestart(1);

    // Games 5-7: player 0 of the three-player instance keeps winning
    playValid(0, 0); playValid(0, 0); playValid(1, 0);
    pulseRestart(1);
    playValid(0, 0); playValid(1, 0);
    pulseRestart(1);
    playValid(1, 0);
    checkOutput("sat B.scores", int'(bScores), 6'h23);
    checkOutput("sat A.scores", int'(aScores), 8'h24);
    pulseRestart(3);
    checkOutput("held A.cur_player", int'(aCur), 1);
    checkOutput("held B.cur_player", int'(bCur), 1);

    // Game 8: abort mid-game, then a win coincident with a score clear
    playValid(0, 0); playValid(0, 0);
    pulseRestart(1);
    checkOutput("abort A.cur_player", int'(aCur), 1);
    checkOutput("abort B.cur_player", int'(bCur), 1);
    checkOutput("abort A.move_cnt", int'(aCnt), 0);
    playValid(1, 1);
    checkOutput("clr A.winner", int'(aWinner), 2'b10);
    checkOutput("clr A.scores", int'(aScores), 0);
    checkOutput("clr B.scores", int'(bScores), 0);
    pulseRestart(1);

    // A move submitted together with restart is dropped
    applyStimulus(1, 0, 0, 1, 0);
    clearInputs();
    checkOutput("drop A.move_cnt", int'(aCnt), 0);
    checkOutput("drop A.en_player", int'(aEn), 2'b01);

    // Asynchronous reset while the invalid indicator is lit
    applyStimulus(1, 1, 0, 0, 0);
    clearInputs();
    applyStimulus(0, 0, 0, 0, 0);
    #2 reset = 1'b0;
    #1;
    checkOutput("areset A.LED_invalid", int'(aLed), 0);
    checkOutput("areset A.en_player", int'(aEn), 1);
    checkOutput("areset B.cur_player", int'(bCur), 0);
    checkOutput("areset A.move_cnt", int'(aCnt), 0);
    @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);

    checkEn = 1'b0;
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
